tl_channel_buffer: RTL
======================

Name: tl_channel_buffer

Overview:
- Parametrised TileLink-UL A/D channel buffer.
- Successor to the flat A/D passthrough bundle: same field set (A: opcode, param, size, source, address, mask, data, corrupt; D: opcode, param, size, source, sink, denied, data, corrupt).
- Adds per-channel ready/valid FIFOs of configurable depth and width to cut timing paths between the core bus and the port fabric.
- DEPTH=0 on a channel degenerates to pure wires.

Parameters:
- ADDR_W, 31, A-channel address width
- DATA_W, 32, data width (multiple of 8); mask width = DATA_W/8
- SRC_W, 3, source ID width
- A_DEPTH, 2, A-channel FIFO entries (0 = passthrough)
- D_DEPTH, 2, D-channel FIFO entries (0 = passthrough)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- a_in_valid  in  1  A request from master
- a_in_ready  out  1  buffer can accept A beat
- a_in_bits  in  A_W  packed A beat; A_W = 9+SRC_W+ADDR_W+DATA_W/8+DATA_W+1 (80 at defaults)
- a_out_valid  out  1  A beat to slave
- a_out_ready  in  1  slave accepts A beat
- a_out_bits  out  A_W  packed A beat
- d_in_valid  in  1  D response from slave
- d_in_ready  out  1  buffer can accept D beat
- d_in_bits  in  D_W  packed D beat; D_W = 11+SRC_W+DATA_W (46 at defaults)
- d_out_valid  out  1  D beat to master
- d_out_ready  in  1  master accepts D beat
- d_out_bits  out  D_W  packed D beat
- a_count  out  $clog2(A_DEPTH+1)  A occupancy
- d_count  out  $clog2(D_DEPTH+1)  D occupancy

Behaviour:
- Channels are independent and identical; no field is inspected or altered. Field order is fixed by the package.
- FIFO state per channel: storage[DEPTH], wr_ptr, rd_ptr, count.
- Enqueue when in_valid & in_ready; dequeue when out_valid & out_ready.
- out_valid = (count != 0). in_ready = (count != DEPTH), registered-path only: in_ready never depends on out_ready. Full decoupling, so at DEPTH=1 throughput is 1 beat per 2 cycles.
- out_bits = storage[rd_ptr].
- Latency: a beat enqueued into an empty FIFO at cycle N is visible on out at N+1.
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Full: in_ready=0, in_valid is ignored, a dequeue frees the slot with in_ready high next cycle.
- Empty: out_valid=0 and out_bits hold the last read entry.
- Pointers wrap DEPTH-1 -> 0; DEPTH need not be a power of two.
- Reset (async assert, sync release): pointers=0, count=0, storage=0, so out_valid=0, in_ready=1, out_bits=0, counts=0. Reset mid-transfer discards all held beats.
- DEPTH=0: out_valid=in_valid, out_bits=in_bits, in_ready=out_ready, count output constant 0, no state.
- out_valid never drops without a handshake. out_bits stays stable while out_valid & !out_ready.

Optional Feature:
- Macro: TL_CHANNEL_BUFFER_FLOW_EN.
- Defined: flow-through when empty (DEPTH>=1).
  - If count==0 and in_valid: out_valid=1, out_bits=in_bits combinationally.
  - If out_ready is also high, the beat bypasses storage and count stays 0.
  - Latency drops to 0.
  - in_ready rule unchanged.
- Undefined: behaviour as above, with no in→out combinational path.

Decomposition:
- Package tl_channel_buffer_pkg holds:
  - TL-UL opcode constants (PutFull 0, PutPartial 1, Get 4, AccessAck 0, AccessAckData 1)
  - field widths and bit offsets for A/D packing
  - A_W/D_W computation functions
- Sub-module tl_buffer_fifo (WIDTH, DEPTH), instantiated once per channel; it contains the flow-feature logic and the DEPTH=0 generate branch.

Test Plan:
- Reset: hold reset_n=0, drive a_in_valid=1 -> a_out_valid=0, a_in_ready=1, a_out_bits=0, a_count=0. Release; beat 0x…AB enqueued at cycle N appears on a_out at N+1.
- Fill/full (A_DEPTH=2, a_out_ready=0): push beats 1, 2 -> a_count=2, a_in_ready=0. Beat 3 is held off. Assert a_out_ready -> outputs 1 then 2, then beat 3 is accepted.
- Streaming (A_DEPTH=2, both sides always valid/ready): 100 beats with incrementing data -> in-order delivery at 1 beat/cycle after 1-cycle fill, a_count steady at 1.
- Wrap/odd depth (D_DEPTH=3): 10 enqueue/dequeue cycles with random backpressure -> order preserved across pointer wrap, d_count never exceeds 3.
- DEPTH=0 on both channels: toggle inputs each cycle -> outputs follow in the same cycle, in_ready equals out_ready.
- FLOW_EN defined, empty FIFO, in_valid=out_ready=1 with data 0x5A -> out_valid=1, out_bits=0x5A in the same cycle, count stays 0. Without the macro, the same beat appears 1 cycle later.

Source files
------------

// File: rtl/tl_channel_buffer_pkg.sv
// TileLink-UL channel buffer shared definitions: opcodes, field widths, beat packing.
// Beats are packed MSB-first in field order: A = opcode,param,size,source,address,mask,data,corrupt.
package tl_channel_buffer_pkg;

    localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_A_GET             = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    localparam int unsigned OPCODE_W  = 3;
    localparam int unsigned A_PARAM_W = 3;
    localparam int unsigned D_PARAM_W = 2;
    localparam int unsigned SIZE_W    = 3;
    localparam int unsigned SINK_W    = 1;
    localparam int unsigned DENIED_W  = 1;
    localparam int unsigned CORRUPT_W = 1;

    // D = opcode,param,size,source,sink,denied,data,corrupt
    function automatic int unsigned a_width(input int unsigned addr_w, input int unsigned data_w,
                                            input int unsigned src_w);
        return OPCODE_W + A_PARAM_W + SIZE_W + src_w + addr_w + data_w / 8 + data_w + CORRUPT_W;
    endfunction

    function automatic int unsigned d_width(input int unsigned src_w, input int unsigned data_w);
        return OPCODE_W + D_PARAM_W + SIZE_W + src_w + SINK_W + DENIED_W + data_w + CORRUPT_W;
    endfunction

    function automatic int unsigned a_data_lsb();
        return CORRUPT_W;
    endfunction

    function automatic int unsigned a_mask_lsb(input int unsigned data_w);
        return CORRUPT_W + data_w;
    endfunction

    function automatic int unsigned a_addr_lsb(input int unsigned data_w);
        return CORRUPT_W + data_w + data_w / 8;
    endfunction

    function automatic int unsigned a_source_lsb(input int unsigned addr_w, input int unsigned data_w);
        return a_addr_lsb(data_w) + addr_w;
    endfunction

    function automatic int unsigned a_size_lsb(input int unsigned addr_w, input int unsigned data_w,
                                               input int unsigned src_w);
        return a_source_lsb(addr_w, data_w) + src_w;
    endfunction

    function automatic int unsigned d_source_lsb(input int unsigned data_w);
        return CORRUPT_W + data_w + DENIED_W + SINK_W;
    endfunction

    // Default-width payloads for software-visible packing (ADDR_W=31, DATA_W=32, SRC_W=3)
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [2:0]  source;
        logic [30:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [2:0]  size;
        logic [2:0]  source;
        logic        sink;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } tl_d_t;

endpackage

// File: rtl/tl_buffer_fifo.sv
// Ready/valid FIFO with fully registered in_ready; DEPTH=0 collapses to wires.
// Optional empty-FIFO flow-through under TL_CHANNEL_BUFFER_FLOW_EN.
module tl_buffer_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bits,
    output logic [CNT_W-1:0] count
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign out_valid = in_valid;
        assign out_bits  = in_bits;
        assign in_ready  = out_ready;
        assign count     = '0;
    end else begin : g_fifo
        localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

        logic [WIDTH-1:0] storage_q [DEPTH];
        logic [WIDTH-1:0] last_q;
        logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0] count_q;
        logic             empty, bypass, push, pop;

        function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
            return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
        endfunction

        assign empty    = (count_q == '0);
        assign in_ready = (count_q != CNT_W'(DEPTH));
        assign count    = count_q;

        // last_q keeps out_bits at the most recently delivered beat while empty
`ifdef TL_CHANNEL_BUFFER_FLOW_EN
        assign bypass    = empty & in_valid & out_ready;
        assign out_valid = !empty | in_valid;
        assign out_bits  = !empty  ? storage_q[rd_ptr_q] :
                           in_valid ? in_bits : last_q;
`else
        assign bypass    = 1'b0;
        assign out_valid = !empty;
        assign out_bits  = empty ? last_q : storage_q[rd_ptr_q];
`endif

        assign push = in_valid & in_ready & !bypass;
        assign pop  = !empty & out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) storage_q[i] <= '0;
                last_q   <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    storage_q[wr_ptr_q] <= in_bits;
                    wr_ptr_q            <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    last_q   <= storage_q[rd_ptr_q];
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end else if (bypass) begin
                    last_q <= in_bits;
                end
                if (push && !pop)      count_q <= count_q + CNT_W'(1);
                else if (pop && !push) count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tl_channel_buffer.sv
// TileLink-UL A/D channel buffer: one independent FIFO per channel, payloads untouched.
// Build option: TL_CHANNEL_BUFFER_FLOW_EN enables zero-latency flow-through when a FIFO is empty.
module tl_channel_buffer
    import tl_channel_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 31,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SRC_W   = 3,
    parameter int unsigned A_DEPTH = 2,
    parameter int unsigned D_DEPTH = 2,
    localparam int unsigned A_W     = a_width(ADDR_W, DATA_W, SRC_W),
    localparam int unsigned D_W     = d_width(SRC_W, DATA_W),
    localparam int unsigned A_CNT_W = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
    localparam int unsigned D_CNT_W = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               a_in_valid,
    output logic               a_in_ready,
    input  logic [A_W-1:0]     a_in_bits,
    output logic               a_out_valid,
    input  logic               a_out_ready,
    output logic [A_W-1:0]     a_out_bits,
    input  logic               d_in_valid,
    output logic               d_in_ready,
    input  logic [D_W-1:0]     d_in_bits,
    output logic               d_out_valid,
    input  logic               d_out_ready,
    output logic [D_W-1:0]     d_out_bits,
    output logic [A_CNT_W-1:0] a_count,
    output logic [D_CNT_W-1:0] d_count
);

    tl_buffer_fifo #(.WIDTH(A_W), .DEPTH(A_DEPTH)) u_a_fifo (
        .clk       (clock),
        .rst_n     (reset_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_bits   (a_in_bits),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_bits  (a_out_bits),
        .count     (a_count)
    );

    tl_buffer_fifo #(.WIDTH(D_W), .DEPTH(D_DEPTH)) u_d_fifo (
        .clk       (clock),
        .rst_n     (reset_n),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_bits   (d_in_bits),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_bits  (d_out_bits),
        .count     (d_count)
    );

endmodule
